// File: rtl/operand_sequencer_pkg.sv
// Shared types for the operand sequencer: FSM state encoding, opcodes and the
// vector-entry layout at the default operand width.
package seq_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StIssue   = 2'd1,
        StWaitRes = 2'd2,
        StFinish  = 2'd3
    } seq_state_e;

    localparam int unsigned OP_ADD = 0;
    localparam int unsigned OP_SUB = 1;

    localparam int unsigned DefWidth = 7;
    localparam int unsigned DefOpw   = 1;

    typedef struct packed {
        logic [DefWidth-1:0] a;
        logic [DefWidth-1:0] b;
        logic [DefOpw-1:0]   op;
        logic [DefWidth:0]   exp;
    } vec_entry_t;

endpackage

// File: rtl/operand_sequencer_if.sv
// Operand issue and result return channel between the sequencer (master) and
// the arithmetic datapath (slave).
interface operand_sequencer_if #(
    parameter int unsigned WIDTH = 7,
    parameter int unsigned OPW   = 1
);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [OPW-1:0]   OP;
    logic             res_valid;
    logic [WIDTH:0]   res_data;

    modport master (
        output out_valid, A, B, OP,
        input  out_ready, res_valid, res_data
    );

    modport slave (
        input  out_valid, A, B, OP,
        output out_ready, res_valid, res_data
    );
endinterface

// File: rtl/operand_sequencer_table.sv
// DEPTH-entry vector register file: synchronous write, asynchronous read,
// asynchronous reset to zero.
module vector_table #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned EW    = 23,
    parameter int unsigned AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [EW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [EW-1:0] rdata_o
);
    logic [EW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (32'(waddr_i) < DEPTH)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = (32'(raddr_i) < DEPTH) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/operand_sequencer.sv
// Programmable vector sequencer: issues table entries to the ALU datapath,
// checks each returned result and reports a saturating mismatch count.
module operand_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned WIDTH = 7,
    parameter int unsigned OPW   = 1,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ERRW  = 8,
    parameter int unsigned AW    = $clog2(DEPTH),
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_we_i,
    input  logic [AW-1:0]        cfg_addr_i,
    input  logic [WIDTH-1:0]     cfg_a_i,
    input  logic [WIDTH-1:0]     cfg_b_i,
    input  logic [OPW-1:0]       cfg_op_i,
    input  logic [WIDTH:0]       cfg_exp_i,
    input  logic [CW-1:0]        vec_count_i,
    input  logic                 start_i,
    input  logic                 loop_en_i,
    input  logic                 abort_i,
    operand_sequencer_if.master  bus,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [ERRW-1:0]      err_count_o,
    output logic                 pass_o
);
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [OPW-1:0]   op;
        logic [WIDTH:0]   exp;
    } entry_t;

    localparam int unsigned EW = $bits(entry_t);

    seq_state_e       state_q, state_d;
    logic [AW-1:0]    index_q, index_d;
    logic [CW-1:0]    count_q, count_d;
    logic             loop_q, loop_d;
    logic             aborted_q, aborted_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [OPW-1:0]   op_q, op_d;
    logic [WIDTH:0]   exp_q, exp_d;
    logic [ERRW-1:0]  err_q, err_d;
    logic             pass_q, pass_d;
    logic             done_q, done_d;

    entry_t           rd_entry;
    logic             tbl_we;
    logic             last_vec;
    logic             issue_next;

    assign tbl_we = cfg_we_i && (state_q == StIdle);

    vector_table #(
        .DEPTH (DEPTH),
        .EW    (EW),
        .AW    (AW)
    ) u_table (
        .clk     (clk),
        .reset   (reset),
        .we_i    (tbl_we),
        .waddr_i (cfg_addr_i),
        .wdata_i ({cfg_a_i, cfg_b_i, cfg_op_i, cfg_exp_i}),
        .raddr_i (index_d),
        .rdata_o (rd_entry)
    );

    assign last_vec = (CW'(index_q) == (count_q - CW'(1)));

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        count_d   = count_q;
        loop_d    = loop_q;
        aborted_d = aborted_q;
        err_d     = err_q;
        pass_d    = pass_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    count_d   = (vec_count_i > CW'(DEPTH)) ? CW'(DEPTH) : vec_count_i;
                    loop_d    = loop_en_i;
                    aborted_d = 1'b0;
                    err_d     = '0;
                    pass_d    = 1'b0;
                    index_d   = '0;
                    state_d   = (count_d == '0) ? StFinish : StIssue;
                end
            end
            StIssue: begin
                if (abort_i) begin
                    aborted_d = 1'b1;
                    state_d   = StFinish;
                end else if (bus.out_ready) begin
                    state_d = StWaitRes;
                end
            end
            StWaitRes: begin
                if (abort_i) begin
                    aborted_d = 1'b1;
                    state_d   = StFinish;
                end else if (bus.res_valid) begin
                    if ((bus.res_data != exp_q) && (err_q != '1)) begin
                        err_d = err_q + ERRW'(1);
                    end
                    if (last_vec) begin
                        if (loop_q) begin
                            index_d = '0;
                            state_d = StIssue;
                        end else begin
                            state_d = StFinish;
                        end
                    end else begin
                        index_d = index_q + AW'(1);
                        state_d = StIssue;
                    end
                end
            end
            StFinish: begin
                done_d  = 1'b1;
                pass_d  = (err_q == '0) && !aborted_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered from the entry the next state will present,
        // so A/B/OP line up with out_valid in the first ISSUE cycle.
        issue_next = (state_d == StIssue);
        valid_d    = issue_next;
        a_d        = issue_next ? rd_entry.a  : '0;
        b_d        = issue_next ? rd_entry.b  : '0;
        op_d       = issue_next ? rd_entry.op : '0;
        exp_d      = issue_next ? rd_entry.exp : exp_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            index_q   <= '0;
            count_q   <= '0;
            loop_q    <= 1'b0;
            aborted_q <= 1'b0;
            valid_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            exp_q     <= '0;
            err_q     <= '0;
            pass_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            count_q   <= count_d;
            loop_q    <= loop_d;
            aborted_q <= aborted_d;
            valid_q   <= valid_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            exp_q     <= exp_d;
            err_q     <= err_d;
            pass_q    <= pass_d;
            done_q    <= done_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.A         = a_q;
    assign bus.B         = b_q;
    assign bus.OP        = op_q;
    assign busy_o        = (state_q != StIdle);
    assign done_o        = done_q;
    assign err_count_o   = err_q;
    assign pass_o        = pass_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// Scoreboard bench for operand_sequencer: directed vectors, a behavioural
// datapath, and a monitor that checks handshakes and done pulses.
module tb_operand_sequencer;
    import seq_pkg::*;

    logic       clk;
    logic       reset;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [6:0] cfg_a, cfg_b;
    logic [0:0] cfg_op;
    logic [7:0] cfg_exp;
    logic [2:0] vec_count;
    logic       start, loop_en, abort;
    logic       busy, done, pass;
    logic [7:0] err_count;

    int checks   = 0;
    int failures = 0;
    int hs_count = 0;

    vec_entry_t exp_vec_q[$];
    logic [8:0] exp_done_q[$];

    operand_sequencer_if #(.WIDTH(7), .OPW(1)) bus ();

    operand_sequencer #(
        .WIDTH (7),
        .OPW   (1),
        .DEPTH (4),
        .ERRW  (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we_i    (cfg_we),
        .cfg_addr_i  (cfg_addr),
        .cfg_a_i     (cfg_a),
        .cfg_b_i     (cfg_b),
        .cfg_op_i    (cfg_op),
        .cfg_exp_i   (cfg_exp),
        .vec_count_i (vec_count),
        .start_i     (start),
        .loop_en_i   (loop_en),
        .abort_i     (abort),
        .bus         (bus),
        .busy_o      (busy),
        .done_o      (done),
        .err_count_o (err_count),
        .pass_o      (pass)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input int addr, input int a, input int b, input int op,
                               input int e);
        cfg_we   = 1'b1;
        cfg_addr = 2'(addr);
        cfg_a    = 7'(a);
        cfg_b    = 7'(b);
        cfg_op   = 1'(op);
        cfg_exp  = 8'(e);
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic push_vec(input int a, input int b, input int op);
        vec_entry_t v;
        v.a   = 7'(a);
        v.b   = 7'(b);
        v.op  = 1'(op);
        v.exp = '0;
        exp_vec_q.push_back(v);
    endtask

    task automatic push_done(input int err, input int p);
        exp_done_q.push_back({8'(err), 1'(p)});
    endtask

    task automatic start_run(input int cnt, input logic lp);
        vec_count = 3'(cnt);
        loop_en   = lp;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // Leaves the bench one cycle past the first idle cycle so the done pulse is seen.
    task automatic wait_idle(input string name);
        for (int n = 0; n < 200; n++) begin
            if (!busy) break;
            tick();
        end
        check(name, int'(busy), 0);
        tick();
    endtask

    // Behavioural ALU: result returned the cycle after each handshake.
    initial begin
        logic [7:0] r;
        bus.res_valid = 1'b0;
        bus.res_data  = '0;
        forever begin
            @(negedge clk);
            if (!reset && bus.out_valid && bus.out_ready) begin
                r = (bus.OP == 1'(OP_SUB)) ? ({1'b0, bus.A} - {1'b0, bus.B})
                                           : ({1'b0, bus.A} + {1'b0, bus.B});
                @(posedge clk);
                #1;
                bus.res_valid = 1'b1;
                bus.res_data  = r;
                @(posedge clk);
                #1;
                bus.res_valid = 1'b0;
            end
        end
    end

    initial begin
        vec_entry_t e;
        logic [8:0] d;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.out_valid && bus.out_ready) begin
                    hs_count++;
                    check("vec_expected", int'(exp_vec_q.size() > 0), 1);
                    if (exp_vec_q.size() > 0) begin
                        e = exp_vec_q.pop_front();
                        check("vec_a", int'(bus.A), int'(e.a));
                        check("vec_b", int'(bus.B), int'(e.b));
                        check("vec_op", int'(bus.OP), int'(e.op));
                    end
                end
                if (done) begin
                    check("done_expected", int'(exp_done_q.size() > 0), 1);
                    if (exp_done_q.size() > 0) begin
                        d = exp_done_q.pop_front();
                        check("done_err_count", int'(err_count), int'(d[8:1]));
                        check("done_pass", int'(pass), int'(d[0]));
                    end
                end
            end
        end
    end

    initial begin
        int base;
        reset         = 1'b1;
        cfg_we        = 1'b0;
        cfg_addr      = '0;
        cfg_a         = '0;
        cfg_b         = '0;
        cfg_op        = '0;
        cfg_exp       = '0;
        vec_count     = '0;
        start         = 1'b0;
        loop_en       = 1'b0;
        abort         = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_a", int'(bus.A), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err_count), 0);
        check("rst_pass", int'(pass), 0);
        reset = 1'b0;
        tick();

        // 1: clean three-vector run
        write_entry(0, 72, 122, OP_ADD, 194);
        write_entry(1, 57, 6, OP_ADD, 63);
        write_entry(2, 2, 2, OP_SUB, 0);
        push_vec(72, 122, OP_ADD);
        push_vec(57, 6, OP_ADD);
        push_vec(2, 2, OP_SUB);
        push_done(0, 1);
        start_run(3, 1'b0);
        check("t1_first_valid", int'(bus.out_valid), 1);
        wait_idle("t1_timeout");
        check("t1_pass", int'(pass), 1);

        // 2: one expected value wrong
        write_entry(1, 57, 6, OP_ADD, 64);
        push_vec(72, 122, OP_ADD);
        push_vec(57, 6, OP_ADD);
        push_vec(2, 2, OP_SUB);
        push_done(1, 0);
        start_run(3, 1'b0);
        wait_idle("t2_timeout");
        check("t2_err", int'(err_count), 1);
        check("t2_pass", int'(pass), 0);

        // 3: back-pressure in ISSUE
        write_entry(1, 57, 6, OP_ADD, 63);
        bus.out_ready = 1'b0;
        base = hs_count;
        push_vec(72, 122, OP_ADD);
        push_vec(57, 6, OP_ADD);
        push_vec(2, 2, OP_SUB);
        push_done(0, 1);
        start_run(3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid", int'(bus.out_valid), 1);
            check("t3_hold_a", int'(bus.A), 72);
            check("t3_hold_b", int'(bus.B), 122);
            check("t3_hold_op", int'(bus.OP), 0);
            tick();
        end
        check("t3_no_hs_while_stalled", hs_count - base, 0);
        bus.out_ready = 1'b1;
        wait_idle("t3_timeout");
        check("t3_hs_total", hs_count - base, 3);

        // 4: empty run
        base = hs_count;
        push_done(0, 1);
        start_run(0, 1'b0);
        check("t4_done_early", int'(done), 0);
        check("t4_no_valid", int'(bus.out_valid), 0);
        tick();
        check("t4_done", int'(done), 1);
        check("t4_pass", int'(pass), 1);
        tick();
        check("t4_no_hs", hs_count - base, 0);

        // 5: loop over two entries, abort in the sixth WAIT_RES
        base = hs_count;
        for (int p = 0; p < 3; p++) begin
            push_vec(72, 122, OP_ADD);
            push_vec(57, 6, OP_ADD);
        end
        push_done(0, 0);
        start_run(2, 1'b1);
        for (int n = 0; n < 100; n++) begin
            if (hs_count - base >= 6) break;
            tick();
        end
        check("t5_hs_count", hs_count - base, 6);
        check("t5_in_wait_busy", int'(busy), 1);
        check("t5_in_wait_valid", int'(bus.out_valid), 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_idle("t5_timeout");
        check("t5_idle", int'(busy), 0);
        check("t5_pass", int'(pass), 0);
        check("t5_hs_after_abort", hs_count - base, 6);

        // 6: reset while stalled in ISSUE with a nonzero error count
        write_entry(0, 72, 122, OP_ADD, 195);
        base = hs_count;
        push_vec(72, 122, OP_ADD);
        start_run(3, 1'b0);
        for (int n = 0; n < 50; n++) begin
            if (hs_count - base >= 1) break;
            tick();
        end
        bus.out_ready = 1'b0;
        tick();
        check("t6_pre_valid", int'(bus.out_valid), 1);
        check("t6_pre_err", int'(err_count), 1);
        reset = 1'b1;
        #1;
        check("t6_rst_valid", int'(bus.out_valid), 0);
        check("t6_rst_a", int'(bus.A), 0);
        check("t6_rst_b", int'(bus.B), 0);
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_err", int'(err_count), 0);
        tick();
        tick();
        reset         = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        // Entry 1 is not rewritten, so it must issue as all zeros.
        write_entry(0, 10, 20, OP_ADD, 30);
        push_vec(10, 20, OP_ADD);
        push_vec(0, 0, OP_ADD);
        push_done(0, 1);
        start_run(2, 1'b0);
        wait_idle("t6_timeout");
        check("t6_pass", int'(pass), 1);

        tick();
        check("vec_queue_drained", exp_vec_q.size(), 0);
        check("done_queue_drained", exp_done_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
